// File: rtl/dmem_arbiter.sv
// Purpose : shares the single-port data memory between the core (priority) and the host/loader port.
// Latency : grant is combinational in the request cycle; read data returns exactly one cycle after the grant.
// Backpress: the losing requester sees gnt=0 and must hold its request; the host is forced through after MAX_WAIT lost cycles.
//
// Ports:
//   clk, rst_n                      - clock (rising edge), asynchronous active-low reset
//   core_req/we/addr/wdata -> gnt   - core load/store request, granted in the same cycle
//   core_rvalid/rdata               - core read return, one cycle after a granted read
//   host_req/we/addr/wdata -> gnt   - host/loader request, granted in the same cycle
//   host_rvalid/rdata               - host read return, one cycle after a granted read
//   dmem_we/addr/wdata, dmem_rdata  - memory side; dmem_rdata is valid one cycle after the address
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata
);

    // MAX_WAIT is limited to 1..15, so four bits hold the saturating count.
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] host_wait_q, host_wait_d;
    logic       rd_core_q, rd_core_d;
    logic       rd_host_q, rd_host_d;
    logic       host_forced;

    // Grant: core wins contention unless the host has already lost MAX_WAIT
    // consecutive cycles, in which case the host takes this slot.
    always_comb begin
        host_forced = (host_wait_q == WAIT_MAX);
        core_gnt    = core_req & ~(host_req & host_forced);
        host_gnt    = host_req & (~core_req | host_forced);
    end

    // Memory drive from whichever requester holds the grant; idle drives zero.
    always_comb begin
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (core_gnt) begin
            dmem_we    = core_we;
            dmem_addr  = core_addr;
            dmem_wdata = core_wdata;
        end else if (host_gnt) begin
            dmem_we    = host_we;
            dmem_addr  = host_addr;
            dmem_wdata = host_wdata;
        end
    end

    // Wait counter counts only consecutive lost host cycles; a grant or a
    // dropped request restarts it from zero.
    always_comb begin
        host_wait_d = '0;
        if (host_req && !host_gnt) begin
            host_wait_d = (host_wait_q >= WAIT_MAX) ? WAIT_MAX : host_wait_q + 4'd1;
        end
    end

    // One flag per owner marks a read in flight; since memory latency is fixed
    // at one cycle, the flag alone steers the returning data to its owner.
    always_comb begin
        rd_core_d = core_gnt & ~core_we;
        rd_host_d = host_gnt & ~host_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_wait_q <= '0;
            rd_core_q   <= 1'b0;
            rd_host_q   <= 1'b0;
        end else begin
            host_wait_q <= host_wait_d;
            rd_core_q   <= rd_core_d;
            rd_host_q   <= rd_host_d;
        end
    end

    // Read data is gated to zero on the port that does not own the return.
    always_comb begin
        core_rvalid = rd_core_q;
        host_rvalid = rd_host_q;
        core_rdata  = rd_core_q ? dmem_rdata : '0;
        host_rdata  = rd_host_q ? dmem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MAXW = 4;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory stub: synchronous single-port RAM, read data one cycle after address.
    logic [31:0] smem [256] = '{default: '0};
    always @(posedge clk) begin
        if (dmem_we) smem[dmem_addr[9:2]] <= dmem_wdata;
        dmem_rdata <= smem[dmem_addr[9:2]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a host loss count, a single "who gets data next cycle"
    // slot with the value the memory held, and a shadow copy of memory.
    int          m_wait;
    int          m_pend;        // 0 none, 1 core, 2 host
    logic [31:0] m_pdata;
    logic [31:0] mmem [256] = '{default: '0};
    logic        last_cg, last_hg;

    task automatic model_reset();
        m_wait = 0;
        m_pend = 0;
    endtask

    initial begin
        logic        ecg, ehg, ewe;
        logic [31:0] ea, ewd;
        model_reset();
        last_cg = 0;
        last_hg = 0;
        forever begin
            @(negedge clk);
            ehg = host_req && (!core_req || m_wait >= MAXW);
            ecg = core_req && !ehg;
            ewe = ecg ? core_we : (ehg ? host_we : 1'b0);
            ea  = ecg ? core_addr : (ehg ? host_addr : 32'h0);
            ewd = ecg ? core_wdata : (ehg ? host_wdata : 32'h0);
            chk("core_gnt", core_gnt, ecg);
            chk("host_gnt", host_gnt, ehg);
            chk("dmem_we", dmem_we, ewe);
            chk("dmem_addr", dmem_addr, ea);
            chk("dmem_wdata", dmem_wdata, ewd);
            chk("core_rvalid", core_rvalid, m_pend == 1);
            chk("core_rdata", core_rdata, (m_pend == 1) ? m_pdata : 32'h0);
            chk("host_rvalid", host_rvalid, m_pend == 2);
            chk("host_rdata", host_rdata, (m_pend == 2) ? m_pdata : 32'h0);
            last_cg = ecg;
            last_hg = ehg;
            if (!rst_n) begin
                model_reset();
            end else begin
                m_pend = 0;
                if ((ecg || ehg) && !ewe) begin
                    m_pend  = ecg ? 1 : 2;
                    m_pdata = mmem[ea[9:2]];
                end
                if ((ecg || ehg) && ewe) mmem[ea[9:2]] = ewd;
                m_wait = (host_req && !ehg) ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, expected under 200000", $time);
        $fatal(1);
    end

    initial begin
        logic [9:0]  pat10;
        logic [4:0]  pat5;
        logic [31:0] r;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with idle requesters: everything zero.
        @(negedge clk);
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_rvalids", {core_rvalid, host_rvalid}, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_outputs", {core_gnt, host_gnt, dmem_we, core_rvalid, host_rvalid}, 0);
        next_cycle();

        // Host preloads 0x14, core writes 0x10.
        drive(0, 0, 0, 0, 1, 1, 32'h14, 32'h12345678);
        @(negedge clk);
        chk("host_wr_gnt", host_gnt, 1);
        next_cycle();
        drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        @(negedge clk);
        chk("core_wr_gnt", core_gnt, 1);
        chk("core_wr_we", dmem_we, 1);
        chk("core_wr_addr", dmem_addr, 32'h10);
        chk("core_wr_data", dmem_wdata, 32'hDEADBEEF);
        next_cycle();

        // Core read 0x10 then host read 0x14 back to back.
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("no_rvalid_after_write", {core_rvalid, host_rvalid}, 0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h14, 0);
        @(negedge clk);
        chk("core_rd_valid", {core_rvalid, host_rvalid}, 2'b10);
        chk("core_rd_data", core_rdata, 32'hDEADBEEF);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("host_rd_valid", {core_rvalid, host_rvalid}, 2'b01);
        chk("host_rd_data", host_rdata, 32'h12345678);
        chk("host_rd_core_zero", core_rdata, 0);
        next_cycle();

        // Continuous contention: host gets every fifth slot.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
            @(negedge clk);
            pat10[i] = host_gnt;
            next_cycle();
        end
        chk("contention_pattern", pat10, 10'b1000010000);

        // Host drops its request at wait=3: counter restarts.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
            next_cycle();
        end
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
            @(negedge clk);
            pat5[i] = host_gnt;
            next_cycle();
        end
        chk("drop_restart_pattern", pat5, 5'b10000);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Reset arrives while a core read is in flight.
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_reset_gnt", core_gnt, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_drops_rvalid", core_rvalid, 0);
        next_cycle();
        rst_n = 1'b1;
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_reset_rvalid_idle", core_rvalid, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_reset_rd_data", core_rdata, 32'hDEADBEEF);
        next_cycle();

        // Random traffic; ungranted requesters hold until granted.
        for (int i = 0; i < 600; i++) begin
            if (!core_req || last_cg) begin
                core_req   = ($urandom_range(0, 9) < 7);
                core_we    = 1'($urandom_range(0, 1));
                r          = $urandom;
                core_addr  = r & 32'hFFFF_FC3F;
                core_wdata = $urandom;
            end
            if (!host_req || last_hg) begin
                host_req   = ($urandom_range(0, 9) < 6);
                host_we    = 1'($urandom_range(0, 1));
                r          = $urandom;
                host_addr  = r & 32'hFFFF_FC3F;
                host_wdata = $urandom;
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor core's load/store port (primary) and a host/loader port used for preloading and inspecting data memory.
- Sits between the core, the host port and the data memory.
- Grants per cycle with core priority. A saturating wait counter guarantees the host a slot after MAX_WAIT lost cycles.
- Tracks each granted read and returns its data to the correct requester one cycle later.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_WAIT, 4, consecutive lost host cycles before host is forced a grant (range 1..15)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- core_req  input  1  core requests access this cycle
- core_we  input  1  1 = write, 0 = read
- core_addr  input  ADDR_W  core byte address
- core_wdata  input  DATA_W  core write data
- core_gnt  output  1  core request accepted this cycle (combinational)
- core_rvalid  output  1  core read data valid
- core_rdata  output  DATA_W  core read data
- host_req  input  1  host requests access this cycle
- host_we  input  1  1 = write, 0 = read
- host_addr  input  ADDR_W  host byte address
- host_wdata  input  DATA_W  host write data
- host_gnt  output  1  host request accepted this cycle (combinational)
- host_rvalid  output  1  host read data valid
- host_rdata  output  DATA_W  host read data
- dmem_we  output  1  data memory write enable
- dmem_addr  output  ADDR_W  data memory address
- dmem_wdata  output  DATA_W  data memory write data
- dmem_rdata  input  DATA_W  data memory read data, valid one cycle after address

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - host_wait = 0; rd_core_q = 0; rd_host_q = 0.
  - core_rvalid = 0, host_rvalid = 0, core_rdata = 0, host_rdata = 0.
  - Grants and dmem outputs follow the combinational rules below. With no request they are 0.
- Arbitration, combinational, same cycle:
  - Neither req: no grant; dmem_we = 0, dmem_addr = 0, dmem_wdata = 0.
  - Only one req: that requester is granted.
  - Both req and host_wait == MAX_WAIT: host granted.
  - Both req otherwise: core granted.
  - Exactly one gnt at most per cycle; core_gnt & host_gnt is never 1.
- Memory drive: dmem_addr and dmem_wdata come from the granted requester. dmem_we = granted requester's we.
- Writes complete in the grant cycle, with no response.
- Wait counter, registered:
  - If host_req & !host_gnt: host_wait <= min(host_wait + 1, MAX_WAIT).
  - If host_gnt or !host_req: host_wait <= 0.
- Read return, registered:
  - rd_core_q <= core_gnt & !core_we; rd_host_q <= host_gnt & !host_we.
  - core_rvalid = rd_core_q; core_rdata = rd_core_q ? dmem_rdata : 0.
  - Same rule for the host port.
  - Read latency: exactly 1 cycle after the grant.
  - A new read may be granted every cycle (fully pipelined). Back-to-back reads to alternating owners each return to the correct owner.
- Ungranted requesters hold req/we/addr/wdata stable until gnt. The arbiter does not buffer requests.
- The core stalls on core_req & !core_gnt.
- Reset mid-operation: pending rvalids are dropped, and host_wait clears immediately (asynchronously).
- No address checking or alignment; addresses pass through unmodified.

Test Plan:
- Reset held, both reqs 0 → all outputs 0. Release rst_n → outputs stay 0, host_wait 0.
- core_req=1, core_we=1, addr 0x10, wdata 0xDEADBEEF, host idle → core_gnt=1 same cycle, dmem_we=1, addr 0x10, no rvalid next cycle.
- Core read 0x10 then host read 0x14 in consecutive cycles → core_rvalid cycle+1 with 0xDEADBEEF. host_rvalid cycle+2 with memory contents of 0x14. No cross-delivery.
- Both req continuously, MAX_WAIT=4 → grant pattern core ×4, host ×1, repeating. host_wait sequence 0,1,2,3,4,0.
- host_req dropped at host_wait=3, then reasserted with core_req → counter restarted from 0, core wins 4 more cycles.
- Core read granted, rst_n pulsed low before next edge → core_rvalid stays 0 after reset; first post-reset read returns correctly.
